// File: rtl/bnn_pkg.sv
// Shared definitions for the binarised network datapath: activation vector
// size, activation width and the vector type used on layer-2 ports.
package bnn_pkg;

  localparam int NUM_ACT = 128;
  localparam int ACT_W   = 8;

  typedef logic [NUM_ACT-1:0][ACT_W-1:0] act_vec_t;

endpackage

// File: rtl/act_bank.sv
// One 128-entry activation bank: LANES-wide write at a beat index, synchronous
// clear, and the full contents always visible on its read port.
module act_bank
  import bnn_pkg::*;
#(
  parameter int WIDTH = ACT_W,
  parameter int LANES = 16,
  localparam int BEATS = NUM_ACT / LANES,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [BEAT_W-1:0]                wr_beat,
  input  logic [LANES-1:0][WIDTH-1:0]      wr_data,
  output logic [NUM_ACT-1:0][WIDTH-1:0]    data
);

  localparam int IDX_W = $clog2(NUM_ACT);

  logic [NUM_ACT-1:0][WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]              idx;

  always_comb begin
    data_d = data_q;
    idx    = '0;
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        idx         = IDX_W'(int'(wr_beat) * LANES + j);
        data_d[idx] = wr_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/act_collector_l2.sv
// Ping-pong collector assembling layer-1 beats into complete activation
// vectors and presenting them, in completion order, to the layer-2 array.
module act_collector_l2
  import bnn_pkg::*;
#(
  parameter int WIDTH = ACT_W,
  parameter int LANES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]    in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_ACT-1:0][WIDTH-1:0]  activations,
  output logic                           frame_err,
  output logic [15:0]                    vec_count
);

  localparam int BEATS  = NUM_ACT / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       vec_count_q, vec_count_d;

  logic accept, fire, at_last, complete, malformed;
  logic [NUM_ACT-1:0][WIDTH-1:0] bank_data [2];

  assign in_ready    = !bank_full_q[wr_sel_q];
  assign out_valid   = bank_full_q[rd_sel_q];
  assign activations = rd_sel_q ? bank_data[1] : bank_data[0];
  assign frame_err   = frame_err_q;
  assign vec_count   = vec_count_q;

  // Completion and fire never hit the same bank: a full write bank blocks input.
  always_comb begin
    accept      = in_valid && in_ready;
    fire        = out_valid && out_ready;
    at_last     = (beat_q == LAST_BEAT);
    complete    = accept && at_last && in_last;
    malformed   = accept && (in_last != at_last);
    bank_full_d = bank_full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    beat_d      = beat_q;
    vec_count_d = vec_count_q;
    frame_err_d = malformed;
    if (fire) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = !rd_sel_q;
      vec_count_d           = vec_count_q + 16'd1;
    end
    if (complete) begin
      bank_full_d[wr_sel_q] = 1'b1;
      wr_sel_d              = !wr_sel_q;
      beat_d                = '0;
    end else if (malformed) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_q      <= '0;
      frame_err_q <= 1'b0;
      vec_count_q <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_q      <= beat_d;
      frame_err_q <= frame_err_d;
      vec_count_q <= vec_count_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(
      .WIDTH(WIDTH),
      .LANES(LANES)
    ) u_bank (
      .clk    (clk),
      .clr    (rst),
      .wr_en  (accept && (wr_sel_q == 1'(b))),
      .wr_beat(beat_q),
      .wr_data(in_data),
      .data   (bank_data[b])
    );
  end

endmodule

// File: tb/tb_act_collector_l2.sv
// Randomised bench for act_collector_l2 against a frame-level model: a queue
// of completed vectors, the position within the current frame and a counter.
module tb_act_collector_l2;
  import bnn_pkg::*;

  localparam int WIDTH = 8;
  localparam int LANES = 16;
  localparam int BEATS = NUM_ACT / LANES;

  typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     in_valid = 1'b0;
  logic     in_last = 1'b0;
  logic     out_ready = 1'b0;
  lanes_t   in_data = '0;
  logic     in_ready, out_valid, frame_err;
  logic [15:0] vec_count;
  act_vec_t activations;

  int checks = 0;
  int errors = 0;

  act_vec_t    exp_q[$];
  act_vec_t    part;
  int          m_beat;
  bit          m_err;
  logic [15:0] m_cnt;
  bit          last_acc;
  int          rate;

  always #5 clk = ~clk;

  act_collector_l2 #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .activations(activations),
    .frame_err  (frame_err),
    .vec_count  (vec_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reports the first differing activation so the message stays short.
  task automatic checkVector(input string tag, input act_vec_t obs, input act_vec_t exp);
    int idx = 0;
    for (int i = NUM_ACT - 1; i >= 0; i--)
      if (obs[7'(i)] !== exp[7'(i)]) idx = i;
    checkOutput($sformatf("%s[%0d]", tag, idx), 32'(obs[7'(idx)]), 32'(exp[7'(idx)]));
  endtask

  function automatic act_vec_t fillVec(input logic [7:0] v);
    act_vec_t r;
    for (int i = 0; i < NUM_ACT; i++) r[7'(i)] = v;
    return r;
  endfunction

  function automatic bit consumerReady();
    return (rate > 0) && ($urandom_range(1, 100) <= rate);
  endfunction

  task automatic checkNow();
    checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    checkOutput("frame_err", 32'(frame_err), 32'(m_err));
    checkOutput("vec_count", 32'(vec_count), 32'(m_cnt));
    if (exp_q.size() > 0) checkVector("activations", activations, exp_q[0]);
  endtask

  task automatic modelStep(input bit v, input lanes_t d, input bit l, input bit r);
    bit fire, acc;
    fire  = (exp_q.size() > 0) && r;
    acc   = v && (exp_q.size() < 2);
    m_err = 1'b0;
    if (fire) begin
      void'(exp_q.pop_front());
      m_cnt++;
    end
    if (acc) begin
      for (int j = 0; j < LANES; j++) part[7'(m_beat * LANES + j)] = d[j];
      if (l && m_beat == BEATS - 1) begin
        exp_q.push_back(part);
        m_beat = 0;
      end else if (l || m_beat == BEATS - 1) begin
        m_err  = 1'b1;
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    last_acc = acc;
  endtask

  task automatic applyStimulus(input bit v, input lanes_t d, input bit l, input bit r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    checkNow();
    modelStep(v, d, l, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_beat = 0;
    m_err  = 1'b0;
    m_cnt  = '0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkVector("rst_act", activations, '0);
  endtask

  function automatic lanes_t makeBeat(input int mode, input logic [7:0] fill, input int k);
    lanes_t b;
    for (int j = 0; j < LANES; j++)
      case (mode)
        0:       b[j] = 8'(k * LANES + j);
        1:       b[j] = fill;
        default: b[j] = 8'($urandom);
      endcase
    return b;
  endfunction

  task automatic sendBeat(input lanes_t d, input bit l);
    int n = 0;
    do begin
      applyStimulus(1'b1, d, l, consumerReady());
      n++;
    end while (!last_acc && n < 300);
    if (!last_acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendFrame(input int nbeats, input bit final_last, input int mode,
                           input logic [7:0] fill, input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        applyStimulus(1'b0, makeBeat(2, 8'h0, k), 1'($urandom), consumerReady());
      sendBeat(makeBeat(mode, fill, k), (k == nbeats - 1) ? final_last : 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, consumerReady());
  endtask

  initial begin
    act_vec_t idxv;
    for (int i = 0; i < NUM_ACT; i++) idxv[7'(i)] = 8'(i);
    rate = 0;
    applyReset();

    // Single vector, held while the consumer stalls
    sendFrame(BEATS, 1'b1, 0, 8'h0, 1'b0);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkVector("t1_index", activations, idxv);
    idle(20);
    checkVector("t1_hold", activations, idxv);
    checkOutput("t1_count", 32'(vec_count), 32'd0);

    // Two banks fill, third vector stalls, then ordered delivery
    applyReset();
    sendFrame(BEATS, 1'b1, 1, 8'h11, 1'b0);
    sendFrame(BEATS, 1'b1, 1, 8'h22, 1'b0);
    checkOutput("t2_stall", 32'(in_ready), 32'd0);
    repeat (3) applyStimulus(1'b1, makeBeat(1, 8'h33, 0), 1'b0, 1'b0);
    checkVector("t2_first", activations, fillVec(8'h11));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    sendFrame(BEATS, 1'b1, 1, 8'h33, 1'b0);
    checkVector("t2_second", activations, fillVec(8'h22));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    checkVector("t2_third", activations, fillVec(8'h33));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t2_count", 32'(vec_count), 32'd3);
    checkOutput("t2_empty", 32'(out_valid), 32'd0);

    // Malformed frames are dropped and flagged
    applyReset();
    sendFrame(4, 1'b1, 1, 8'h55, 1'b0);
    checkOutput("t3_err_early", 32'(frame_err), 32'd1);
    sendFrame(BEATS, 1'b1, 1, 8'h7F, 1'b0);
    checkVector("t3_good", activations, fillVec(8'h7F));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    sendFrame(BEATS, 1'b0, 1, 8'h44, 1'b0);
    checkOutput("t3_err_late", 32'(frame_err), 32'd1);
    idle(3);
    checkOutput("t3_none", 32'(out_valid), 32'd0);
    checkOutput("t3_count", 32'(vec_count), 32'd1);

    // Continuous streaming with an always-ready consumer
    rate = 100;
    for (int f = 0; f < 6; f++) sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    idle(2);
    checkOutput("t4_count", 32'(vec_count), 32'd7);

    // Reset mid-frame and with both banks full
    rate = 0;
    sendFrame(3, 1'b0, 2, 8'h0, 1'b0);
    applyReset();
    sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    applyReset();
    rate = 100;
    sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    idle(2);
    checkOutput("t5_count", 32'(vec_count), 32'd1);

    // Counter wrap from a preloaded value
    applyReset();
    force dut.vec_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.vec_count_q;
    m_cnt = 16'hFFFE;
    sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    idle(1);
    checkOutput("t6_ffff", 32'(vec_count), 32'hFFFF);
    sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b0);
    idle(1);
    checkOutput("t6_wrap", 32'(vec_count), 32'h0);

    // Random mix of good and malformed frames with a bursty consumer
    applyReset();
    rate = 50;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 5))
        0:       sendFrame($urandom_range(1, BEATS - 1), 1'b1, 2, 8'h0, 1'b1);
        1:       sendFrame(BEATS, 1'b0, 2, 8'h0, 1'b1);
        default: sendFrame(BEATS, 1'b1, 2, 8'h0, 1'b1);
      endcase
    end
    rate = 100;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_collector_l2.md
# act_collector_l2

Ping-pong buffer that sits directly upstream of the layer-2 neuron array. It collects layer-1 neuron outputs, which arrive LANES values per beat, into a complete 128-entry activation vector. It then presents that vector as a stable, registered bus on the layer-2 `activations` input. Two banks allow the next vector to be filled while layer 2 consumes the current one. Malformed frames are dropped and flagged.

## Interface
- WIDTH, 8, bits per activation (two's complement); must equal the layer-2 WIDTH_IN
- LANES, 16, activations per input beat; must divide 128 (BEATS = 128/LANES)
- clk  in  1  single clock, all logic posedge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  [LANES-1:0][WIDTH-1:0]  lane j of beat k maps to activation k*LANES+j
- in_last  in  1  marks the final beat of a vector
- out_valid  out  1  complete vector available
- out_ready  in  1  consumer takes the vector when out_valid && out_ready
- activations  out  [127:0][WIDTH-1:0]  contents of the read bank
- frame_err  out  1  one-cycle pulse when a frame is dropped
- vec_count  out  16  count of vectors delivered; wraps 0xFFFF->0

## Operation
- State: two banks of 128×WIDTH registers; bank_full[1:0], wr_sel, rd_sel, beat counter (0..BEATS-1).
- in_ready = !bank_full[wr_sel].
- out_valid = bank_full[rd_sel].
- activations = bank[rd_sel].
- Accepted beat: lanes are written to bank[wr_sel] at slot beat*LANES.
  - beat < BEATS-1 with in_last=0: beat increments.
  - beat == BEATS-1 with in_last=1: set bank_full[wr_sel], toggle wr_sel, beat←0.
- Malformed frame: in_last=1 on beat < BEATS-1, or in_last=0 on beat == BEATS-1.
  - frame_err pulses the next cycle and beat←0.
  - The bank is not marked full; its partial contents are overwritten by the next frame.
- Output fire (out_valid && out_ready): clear bank_full[rd_sel], toggle rd_sel, vec_count+1.
- Simultaneous completion and output fire always target different banks; both updates take effect in the same cycle.
- Both banks full: in_ready=0. Inputs are ignored until an output fire.
- Ordering: vectors are delivered strictly in completion order; no vector is ever skipped or duplicated.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, frame_err=0, vec_count=0, activations=0.
  - bank_full=0, wr_sel=rd_sel=0, beat=0, both banks cleared to 0.
- Reset mid-frame or with banks full discards everything; the block is ready the cycle after rst deasserts.
- Latency: final beat accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1) when that bank is the read bank.
- activations is held stable while out_valid && !out_ready.
  - It changes only at an output fire, and only to the other bank's contents, or to stale data with out_valid=0.
- in_ready goes low in the cycle after the beat that fills the second bank.
  - It returns high in the cycle after the output fire that frees a bank.
  - The input side has no combinational dependence on out_ready.
- Throughput: one vector per BEATS cycles with no stall, provided the consumer fires at least once every BEATS cycles.
- frame_err is registered: high for exactly one cycle after the offending beat is accepted.

## Structure
- Shared package bnn_pkg holds:
  - NUM_ACT=128 and the ACT_W localparam.
  - The activation vector typedef, `logic [NUM_ACT-1:0][ACT_W-1:0]`, reused by the layer-2 neuron ports.
- Sub-module act_bank (one 128×WIDTH bank with LANES-wide write at a beat index and synchronous clear), instantiated twice.
- Top level holds the counters, selects, full flags, output mux and error logic.

## Test plan
- Reset, then 8 beats (LANES=16) with lane value = activation index, in_last on beat 7, out_ready=0:
  - out_valid=1 the cycle after beat 7.
  - activations[i]=i for all i.
  - Held for 20 cycles; vec_count=0.
- Three back-to-back vectors with out_ready=0 (values 0x11, 0x22, 0x33):
  - in_ready drops after the second vector; the third vector's beats stall.
  - Pulse out_ready three times: 0x11, 0x22, 0x33 are seen in order; vec_count=3.
- in_last on beat 3, then a valid 8-beat frame of 0x7F:
  - frame_err pulses once.
  - The only delivered vector is all 0x7F.
  - A frame with in_last missing on beat 7 also pulses frame_err and is not delivered.
- out_ready held 1 with continuous input:
  - Completion and output fire coincide.
  - No vector is lost; vec_count increments every 8 cycles; in_ready stays 1.
- rst asserted mid-frame and with both banks full:
  - Next cycle: out_valid=0, in_ready=1, activations=0.
  - The next full frame is delivered normally.
- Preload vec_count near wrap (0xFFFE) via 2 deliveries after force: reads 0xFFFF, then 0x0000.
